key_debounce: RTL and testbench
===============================

Name: key_debounce

Overview:
- Cleans a raw mechanical push-button input before it reaches the board's registered logic.
- Synchronises the asynchronous pin into clk, rejects contact bounce with a stability counter, and produces a clean level plus single-cycle press, release and long-press pulses.
- Sits directly between the board pin and the downstream flip-flop/counter stages; key_level is the signal those stages register.

Parameters:
- CNT_MAX, default 1_000_000, number of consecutive stable clk samples required to accept a change (20 ms at 50 MHz); legal range >= 2.
- LONG_MAX, default 50_000_000, clk cycles the key must stay accepted-pressed before key_long fires (1 s at 50 MHz); legal range >= 1.
- KEY_ACTIVE, default 1'b0, pin level meaning "pressed" (board keys are active-low).
- Counter widths are derived as $clog2(CNT_MAX+1) and $clog2(LONG_MAX+1).

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- key_in  input  1  raw, asynchronous, bouncing key pin
- key_level  output  1  debounced state, 1 = pressed (polarity normalised)
- key_press  output  1  one-cycle pulse on accepted press
- key_release  output  1  one-cycle pulse on accepted release
- key_long  output  1  one-cycle pulse, once per press, after LONG_MAX cycles held

Behaviour:
- Reset: rst_n is asynchronous, active-low, clock clk; deassertion is synchronous to clk by the board reset tree.
- Reset values: both synchroniser flops = ~KEY_ACTIVE; FSM = IDLE; all counters = 0; key_level = key_press = key_release = key_long = 0.
- Reset mid-operation: aborts any filter or long count immediately; no pulse is emitted on reset entry or exit.
- A key held through reset is re-filtered from IDLE and yields key_press after the normal latency.
- Synchroniser: two flops, sync1 <= key_in, key_s <= sync1. The FSM uses only key_s; active = (key_s == KEY_ACTIVE).
- All outputs are registered; no combinational path from key_in to any output.
- FSM states and transitions, evaluated each rising edge:
  - IDLE (key_level = 0): if active -> PRESS_FILT, cnt <= 1; else stay, cnt <= 0.
  - PRESS_FILT: if !active -> IDLE, cnt <= 0, no pulse. Else if cnt == CNT_MAX-1 -> PRESSED, key_level <= 1, key_press <= 1, lcnt <= 0. Else cnt <= cnt+1.
  - PRESSED (key_level = 1): if !active -> REL_FILT, cnt <= 1. Else, if long not yet fired, lcnt <= lcnt+1; when lcnt == LONG_MAX-1, key_long <= 1 and the long-fired flag is set.
  - REL_FILT: if active -> PRESSED, cnt <= 0; lcnt keeps counting and the long-fired flag is unchanged. Else if cnt == CNT_MAX-1 -> IDLE, key_level <= 0, key_release <= 1, long-fired flag cleared. Else cnt <= cnt+1.
- Net effect: a change is accepted only after exactly CNT_MAX consecutive samples of key_s at the new level. Any opposite sample restarts filtering from the previous accepted state.
- Latency: if key_in is stable at the new level from rising edge e0 onward, the pulse register sets at edge e0+CNT_MAX+1 and clears at e0+CNT_MAX+2. key_level changes at the same edge.
- Pulses: each pulse is exactly one cycle. key_press and key_release never assert together. key_long asserts at most once per accepted press and never when key_level = 0.
- Long-press timing: key_long sets LONG_MAX cycles after key_press; cycles spent in REL_FILT bounce are counted.
- Counters saturate by construction: cnt never exceeds CNT_MAX-1, lcnt stops once long has fired. No wrap-around.

Test Plan:
- Clean press (CNT_MAX=4, LONG_MAX=10): key_in 1->0 before edge e0, held -> key_press high exactly one cycle from e0+5; key_level = 1 from e0+5; no key_release.
- Bounce reject (CNT_MAX=4): key_in toggles 0,1,0,1 on consecutive edges, then held 0 from edge e1 -> no pulse during toggling; single key_press at e1+5.
- Glitch while pressed (CNT_MAX=4): after press, 2-cycle high glitch -> key_level stays 1, no key_release. A later 4+ cycle clean release -> one key_release, key_level = 0.
- Long press (CNT_MAX=4, LONG_MAX=10): hold 40 cycles -> key_press once, key_long exactly once 10 cycles after key_press. Release -> key_release; a second press re-arms key_long.
- Reset mid-filter: assert rst_n = 0 while in PRESS_FILT with cnt=2 -> all outputs 0 immediately. Key still held after deassert -> key_press 4+1 cycles after the synchroniser sees the key, no spurious release.
- Short tap below threshold (CNT_MAX=4): key_in low for 3 edges only -> no outputs change.

Source files
------------

// File: rtl/key_debounce.sv
// Push-button conditioner: two-flop synchroniser, stability-count debounce filter and
// registered press / release / long-press pulses.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   key_in      raw, asynchronous, bouncing key pin
//   key_level   debounced key state, 1 = pressed regardless of pin polarity
//   key_press   one-cycle pulse when a press is accepted
//   key_release one-cycle pulse when a release is accepted
//   key_long    one-cycle pulse, once per press, LONG_MAX cycles after key_press
module key_debounce #(
  parameter int unsigned CNT_MAX    = 1_000_000,
  parameter int unsigned LONG_MAX   = 50_000_000,
  parameter logic        KEY_ACTIVE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int unsigned CW = $clog2(CNT_MAX + 1);
  localparam int unsigned LW = $clog2(LONG_MAX + 1);

  localparam logic [CW-1:0] CntLast  = CW'(CNT_MAX - 1);
  localparam logic [LW-1:0] LongLast = LW'(LONG_MAX - 1);

  typedef enum logic [1:0] {
    StIdle,
    StPressFilt,
    StPressed,
    StRelFilt
  } state_e;

  state_e        state_q, state_d;
  logic          sync1_q, key_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic          fired_q, fired_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          long_q, long_d;
  logic          active;
  logic          long_tick;

  assign active = (key_s_q == KEY_ACTIVE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= ~KEY_ACTIVE;
      key_s_q   <= ~KEY_ACTIVE;
      state_q   <= StIdle;
      cnt_q     <= '0;
      lcnt_q    <= '0;
      fired_q   <= 1'b0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      sync1_q   <= key_in;
      key_s_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      lcnt_q    <= lcnt_d;
      fired_q   <= fired_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lcnt_d    = lcnt_q;
    fired_d   = fired_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    long_tick = 1'b0;

    case (state_q)
      StIdle: begin
        level_d = 1'b0;
        if (active) begin
          state_d = StPressFilt;
          cnt_d   = CW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      StPressFilt: begin
        if (!active) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StPressed;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
          lcnt_d  = '0;
          fired_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StPressed: begin
        long_tick = 1'b1;
        if (!active) begin
          state_d = StRelFilt;
          cnt_d   = CW'(1);
        end else begin
          cnt_d = '0;
        end
      end
      StRelFilt: begin
        if (active) begin
          // Bounce back to pressed: the long-press count carries on uninterrupted.
          state_d   = StPressed;
          cnt_d     = '0;
          long_tick = 1'b1;
        end else if (cnt_q == CntLast) begin
          state_d   = StIdle;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
          fired_d   = 1'b0;
        end else begin
          cnt_d     = cnt_q + CW'(1);
          long_tick = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase

    // Long-press counter freezes once it has fired, so it never wraps.
    if (long_tick && !fired_q) begin
      if (lcnt_q == LongLast) begin
        long_d  = 1'b1;
        fired_d = 1'b1;
      end else begin
        lcnt_d = lcnt_q + LW'(1);
      end
    end
  end

  assign key_level   = level_q;
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_long    = long_q;

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: directed scenarios followed by random key
// activity, compared every cycle against a run-length reference model.
module tb_key_debounce;

  localparam int unsigned CNT_MAX    = 4;
  localparam int unsigned LONG_MAX   = 10;
  localparam logic        KEY_ACTIVE = 1'b0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic key_in = 1'b1;
  logic key_level, key_press, key_release, key_long;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic m_s1, m_s;
  logic e_level, e_press, e_release, e_long;
  int   run, since;
  bit   fired;

  // Observed pulse bookkeeping
  int cyc = 0;
  int n_press = 0, n_release = 0, n_long = 0;
  int last_press_cyc = 0, last_long_cyc = 0;
  int base, p0, r0, l0;

  key_debounce #(
    .CNT_MAX   (CNT_MAX),
    .LONG_MAX  (LONG_MAX),
    .KEY_ACTIVE(KEY_ACTIVE)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_in     (key_in),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_s1 = ~KEY_ACTIVE;
    m_s = ~KEY_ACTIVE;
    e_level = 1'b0;
    e_press = 1'b0;
    e_release = 1'b0;
    e_long = 1'b0;
    run = 0;
    since = 0;
    fired = 1'b0;
  endtask

  // Drive one key sample for one clock edge, advance the model, then check outputs.
  task automatic step(input logic k);
    logic ks;
    @(negedge clk);
    key_in = k;
    @(posedge clk);
    cyc++;
    ks = m_s;
    m_s = m_s1;
    m_s1 = k;
    e_press = 1'b0;
    e_release = 1'b0;
    e_long = 1'b0;
    // A change is accepted after CNT_MAX consecutive samples differing from the level.
    if ((ks == KEY_ACTIVE) != e_level) run++;
    else run = 0;
    if (run == CNT_MAX) begin
      run = 0;
      e_level = ~e_level;
      fired = 1'b0;
      if (e_level) begin
        e_press = 1'b1;
        since = 0;
      end else begin
        e_release = 1'b1;
      end
    end else if (e_level && !fired) begin
      since++;
      if (since == LONG_MAX) begin
        e_long = 1'b1;
        fired = 1'b1;
      end
    end
    #1;
    chk("key_level", int'(key_level), int'(e_level));
    chk("key_press", int'(key_press), int'(e_press));
    chk("key_release", int'(key_release), int'(e_release));
    chk("key_long", int'(key_long), int'(e_long));
    if (key_press) begin
      n_press++;
      last_press_cyc = cyc;
    end
    if (key_release) n_release++;
    if (key_long) begin
      n_long++;
      last_long_cyc = cyc;
    end
  endtask

  // Assert reset between edges, check outputs clear at once, release just after an edge.
  task automatic apply_reset(input logic k, input int hold);
    key_in = k;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_level", int'(key_level), 0);
    chk("rst_press", int'(key_press), 0);
    chk("rst_release", int'(key_release), 0);
    chk("rst_long", int'(key_long), 0);
    model_reset();
    repeat (hold) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic snap();
    base = cyc;
    p0 = n_press;
    r0 = n_release;
    l0 = n_long;
  endtask

  initial begin
    model_reset();
    #1;
    apply_reset(1'b1, 3);

    // Idle settle
    repeat (5) step(1'b1);

    // Clean press
    snap();
    repeat (12) step(1'b0);
    chk("clean_press_count", n_press - p0, 1);
    chk("clean_press_latency", last_press_cyc - base, CNT_MAX + 2);
    chk("clean_no_release", n_release - r0, 0);

    // Two-cycle glitch while pressed must not release
    snap();
    repeat (2) step(1'b1);
    repeat (6) step(1'b0);
    chk("glitch_no_release", n_release - r0, 0);
    snap();
    repeat (10) step(1'b1);
    chk("clean_release_count", n_release - r0, 1);

    // Bounce then a clean hold
    snap();
    step(1'b0);
    step(1'b1);
    step(1'b0);
    step(1'b1);
    base = cyc;
    repeat (10) step(1'b0);
    chk("bounce_press_count", n_press - p0, 1);
    chk("bounce_press_latency", last_press_cyc - base, CNT_MAX + 2);
    repeat (10) step(1'b1);

    // Long press, then a second press re-arms it
    snap();
    repeat (40) step(1'b0);
    chk("long_press_count", n_press - p0, 1);
    chk("long_count", n_long - l0, 1);
    chk("long_latency", last_long_cyc - last_press_cyc, LONG_MAX);
    snap();
    repeat (10) step(1'b1);
    chk("long_release_count", n_release - r0, 1);
    snap();
    repeat (20) step(1'b0);
    chk("long_rearm_count", n_long - l0, 1);
    repeat (10) step(1'b1);

    // Short tap below threshold
    snap();
    repeat (3) step(1'b0);
    repeat (10) step(1'b1);
    chk("tap_no_press", n_press - p0, 0);
    chk("tap_no_release", n_release - r0, 0);

    // Reset while filtering a press, key still held afterwards
    repeat (4) step(1'b0);
    apply_reset(1'b0, 2);
    snap();
    repeat (10) step(1'b0);
    chk("rst_held_press_count", n_press - p0, 1);
    chk("rst_held_press_latency", last_press_cyc - base, CNT_MAX + 2);
    chk("rst_held_no_release", n_release - r0, 0);
    repeat (10) step(1'b1);

    // Random runs of mixed lengths: bounces, accepted edges and long holds
    for (int r = 0; r < 300; r++) begin
      logic v;
      int len;
      v = logic'($urandom_range(0, 1));
      len = int'($urandom_range(1, 20));
      for (int i = 0; i < len; i++) step(v);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
